// File: rtl/ecc_pipe_pkg.sv
// Shared widths, decode result type and small helpers for the pipelined SECDED engine.
package ecc_pipe_pkg;

  localparam int DATA_W   = 64;
  localparam int PARITY_B = 7;
  localparam int EW       = PARITY_B + 1;

  function automatic int lane_idx_w(input int lanes);
    return (lanes > 1) ? $clog2(lanes) : 1;
  endfunction

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              sbe;
    logic              dbe;
    logic [EW-1:0]     syn;
  } dec_res_t;

  // a + b clamped to the largest w-bit value
  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b, input int w);
    logic [32:0] sum;
    logic [32:0] lim;
    sum = {1'b0, a} + {1'b0, b};
    lim = (33'd1 << w) - 33'd1;
    return (sum > lim) ? lim[31:0] : sum[31:0];
  endfunction

endpackage

// File: rtl/ecc_err_log.sv
// Saturating SBE/DBE lane counters and a first-error log with DBE upgrade; clear beats update.
module ecc_err_log
  import ecc_pipe_pkg::*;
#(
  parameter int LANES      = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int CNT_WIDTH  = 16,
  parameter int LW         = lane_idx_w(LANES)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      upd,
  input  logic                      err_clr,
  input  logic [LANES-1:0]          sbe,
  input  logic [LANES-1:0]          dbe,
  input  logic [ADDR_WIDTH-1:0]     addr,
  input  logic [LANES-1:0][EW-1:0]  syn,
  output logic [CNT_WIDTH-1:0]      sbe_cnt,
  output logic [CNT_WIDTH-1:0]      dbe_cnt,
  output logic                      log_valid,
  output logic                      log_is_dbe,
  output logic [ADDR_WIDTH-1:0]     log_addr,
  output logic [LW-1:0]             log_lane,
  output logic [EW-1:0]             log_syndrome,
  output logic                      irq_dbe
);

  logic [31:0]   sbe_pop;
  logic [31:0]   dbe_pop;
  logic [LW-1:0] sel_d;
  logic [LW-1:0] sel_s;
  logic [LW-1:0] sel;
  logic          any_dbe;
  logic          any_err;
  logic          log_wr;

  // Descending scan so the lowest erroring lane wins
  always_comb begin
    sbe_pop = '0;
    dbe_pop = '0;
    sel_d   = '0;
    sel_s   = '0;
    for (int l = LANES - 1; l >= 0; l--) begin
      if (dbe[l]) sel_d = LW'(l);
      if (sbe[l]) sel_s = LW'(l);
      sbe_pop = sbe_pop + 32'(sbe[l]);
      dbe_pop = dbe_pop + 32'(dbe[l]);
    end
    any_dbe = |dbe;
    any_err = |(sbe | dbe);
    sel     = any_dbe ? sel_d : sel_s;
  end

  assign log_wr  = upd & any_err & (~log_valid | (~log_is_dbe & any_dbe));
  assign irq_dbe = log_valid & log_is_dbe;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sbe_cnt      <= '0;
      dbe_cnt      <= '0;
      log_valid    <= 1'b0;
      log_is_dbe   <= 1'b0;
      log_addr     <= '0;
      log_lane     <= '0;
      log_syndrome <= '0;
    end else if (err_clr) begin
      sbe_cnt      <= '0;
      dbe_cnt      <= '0;
      log_valid    <= 1'b0;
      log_is_dbe   <= 1'b0;
      log_addr     <= '0;
      log_lane     <= '0;
      log_syndrome <= '0;
    end else if (upd) begin
      sbe_cnt <= CNT_WIDTH'(sat_add(32'(sbe_cnt), sbe_pop, CNT_WIDTH));
      dbe_cnt <= CNT_WIDTH'(sat_add(32'(dbe_cnt), dbe_pop, CNT_WIDTH));
      if (log_wr) begin
        log_valid    <= 1'b1;
        log_is_dbe   <= any_dbe;
        log_addr     <= addr;
        log_lane     <= sel;
        log_syndrome <= syn[sel];
      end
    end
  end

endmodule

// File: rtl/ecc_secded.sv
// One-lane Hamming(71,64)+overall-parity SECDED: check-bit generation and decode/correct.
module ecc_secded
  import ecc_pipe_pkg::*;
(
  input  logic [DATA_W-1:0] data_in,
  input  logic [EW-1:0]     ecc_in,
  output logic [EW-1:0]     ecc_gen,
  output dec_res_t          dec
);

  localparam int NPOS = DATA_W + PARITY_B;

  logic [PARITY_B-1:0] calc;
  logic [PARITY_B-1:0] syn;
  logic                ovr;
  logic                sbe;
  logic                dbe;

  // Data bits occupy the non-power-of-two codeword positions 3,5,6,7,9,...
  always_comb begin
    int di;
    calc = '0;
    di   = 0;
    for (int p = 1; p <= NPOS; p++) begin
      if ((p & (p - 1)) != 0) begin
        for (int i = 0; i < PARITY_B; i++)
          if (p[i]) calc[i] = calc[i] ^ data_in[di];
        di++;
      end
    end
  end

  assign ecc_gen = {(^data_in) ^ (^calc), calc};
  assign syn     = ecc_in[PARITY_B-1:0] ^ calc;
  assign ovr     = (^data_in) ^ (^ecc_in);
  // Odd overall parity with a syndrome outside the codeword is a multi-bit error
  assign sbe     = ovr & (int'(syn) <= NPOS);
  assign dbe     = (~ovr & (syn != '0)) | (ovr & (int'(syn) > NPOS));

  always_comb begin
    int dj;
    dec      = '0;
    dec.data = data_in;
    dj       = 0;
    for (int p = 1; p <= NPOS; p++) begin
      if ((p & (p - 1)) != 0) begin
        if (sbe && (int'(syn) == p)) dec.data[dj] = ~data_in[dj];
        dj++;
      end
    end
    dec.sbe = sbe;
    dec.dbe = dbe;
    dec.syn = {ovr, syn};
  end

endmodule

// File: rtl/ecc_pipe_engine.sv
// Multi-lane SECDED engine: 1-stage registered encode, 2-stage registered decode, error RAS log.
module ecc_pipe_engine
  import ecc_pipe_pkg::*;
#(
  parameter int LANES       = 2,
  parameter int DATA_WIDTH  = DATA_W,
  parameter int PARITY_BITS = PARITY_B,
  parameter int ADDR_WIDTH  = 32,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 ecc_en,
  input  logic                                 wr_in_valid,
  output logic                                 wr_in_ready,
  input  logic [LANES*DATA_WIDTH-1:0]          wr_in_data,
  output logic                                 wr_out_valid,
  input  logic                                 wr_out_ready,
  output logic [LANES*DATA_WIDTH-1:0]          wr_out_data,
  output logic [LANES*(PARITY_BITS+1)-1:0]     wr_out_ecc,
  input  logic                                 rd_in_valid,
  output logic                                 rd_in_ready,
  input  logic [LANES*DATA_WIDTH-1:0]          rd_in_data,
  input  logic [LANES*(PARITY_BITS+1)-1:0]     rd_in_ecc,
  input  logic [ADDR_WIDTH-1:0]                rd_in_addr,
  output logic                                 rd_out_valid,
  input  logic                                 rd_out_ready,
  output logic [LANES*DATA_WIDTH-1:0]          rd_out_data,
  output logic [ADDR_WIDTH-1:0]                rd_out_addr,
  output logic [LANES-1:0]                     rd_out_sbe,
  output logic [LANES-1:0]                     rd_out_dbe,
  input  logic                                 err_clr,
  output logic [CNT_WIDTH-1:0]                 sbe_cnt,
  output logic [CNT_WIDTH-1:0]                 dbe_cnt,
  output logic                                 log_valid,
  output logic                                 log_is_dbe,
  output logic [ADDR_WIDTH-1:0]                log_addr,
  output logic [lane_idx_w(LANES)-1:0]         log_lane,
  output logic [PARITY_BITS:0]                 log_syndrome,
  output logic                                 irq_dbe
);

  localparam int LW = lane_idx_w(LANES);

  // ---------------- write path ----------------
  logic [LANES-1:0][DATA_WIDTH-1:0] wr_lane_d;
  logic [LANES-1:0][EW-1:0]         wr_ecc_gen;
  dec_res_t [LANES-1:0]             enc_unused_dec;

  assign wr_lane_d   = wr_in_data;
  assign wr_in_ready = ~wr_out_valid | wr_out_ready;

  for (genvar l = 0; l < LANES; l++) begin : g_enc
    ecc_secded u_enc (
      .data_in (wr_lane_d[l]),
      .ecc_in  ('0),
      .ecc_gen (wr_ecc_gen[l]),
      .dec     (enc_unused_dec[l])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_out_valid <= 1'b0;
      wr_out_data  <= '0;
      wr_out_ecc   <= '0;
    end else if (wr_in_valid & wr_in_ready) begin
      wr_out_valid <= 1'b1;
      wr_out_data  <= wr_in_data;
      wr_out_ecc   <= ecc_en ? wr_ecc_gen : '0;
    end else if (wr_out_ready) begin
      wr_out_valid <= 1'b0;
    end
  end

  // ---------------- read path ----------------
  logic [2:1]                       vld_pipe;
  logic                             s1_en;
  logic                             s2_en;
  logic [LANES-1:0][DATA_WIDTH-1:0] s1_data;
  logic [LANES-1:0][EW-1:0]         s1_ecc;
  logic [ADDR_WIDTH-1:0]            s1_addr;
  logic                             s1_ecc_en;
  dec_res_t [LANES-1:0]             s1_dec;
  logic [LANES-1:0][EW-1:0]         dec_unused_gen;
  logic [LANES-1:0][DATA_WIDTH-1:0] s2_data_nxt;
  logic [LANES-1:0]                 s2_sbe_nxt;
  logic [LANES-1:0]                 s2_dbe_nxt;
  logic [LANES-1:0][EW-1:0]         s2_syn_nxt;

  assign s2_en        = ~vld_pipe[2] | rd_out_ready;
  assign s1_en        = ~vld_pipe[1] | s2_en;
  assign rd_in_ready  = s1_en;
  assign rd_out_valid = vld_pipe[2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe    <= '0;
      s1_data     <= '0;
      s1_ecc      <= '0;
      s1_addr     <= '0;
      s1_ecc_en   <= 1'b0;
      rd_out_data <= '0;
      rd_out_addr <= '0;
      rd_out_sbe  <= '0;
      rd_out_dbe  <= '0;
    end else begin
      if (s1_en) begin
        vld_pipe[1] <= rd_in_valid;
        if (rd_in_valid) begin
          s1_data   <= rd_in_data;
          s1_ecc    <= rd_in_ecc;
          s1_addr   <= rd_in_addr;
          s1_ecc_en <= ecc_en;
        end
      end
      if (s2_en) begin
        vld_pipe[2] <= vld_pipe[1];
        if (vld_pipe[1]) begin
          rd_out_data <= s2_data_nxt;
          rd_out_addr <= s1_addr;
          rd_out_sbe  <= s2_sbe_nxt;
          rd_out_dbe  <= s2_dbe_nxt;
        end
      end
    end
  end

  for (genvar l = 0; l < LANES; l++) begin : g_dec
    ecc_secded u_dec (
      .data_in (s1_data[l]),
      .ecc_in  (s1_ecc[l]),
      .ecc_gen (dec_unused_gen[l]),
      .dec     (s1_dec[l])
    );
  end

  // Bypass passes raw data with flags forced low; latency is unaffected
  always_comb begin
    s2_data_nxt = '0;
    s2_sbe_nxt  = '0;
    s2_dbe_nxt  = '0;
    s2_syn_nxt  = '0;
    for (int l = 0; l < LANES; l++) begin
      s2_data_nxt[l] = s1_ecc_en ? s1_dec[l].data : s1_data[l];
      s2_sbe_nxt[l]  = s1_ecc_en & s1_dec[l].sbe;
      s2_dbe_nxt[l]  = s1_ecc_en & s1_dec[l].dbe;
      s2_syn_nxt[l]  = s1_dec[l].syn;
    end
  end

  ecc_err_log #(
    .LANES      (LANES),
    .ADDR_WIDTH (ADDR_WIDTH),
    .CNT_WIDTH  (CNT_WIDTH),
    .LW         (LW)
  ) u_err_log (
    .clk          (clk),
    .rst_n        (rst_n),
    .upd          (vld_pipe[1] & s2_en),
    .err_clr      (err_clr),
    .sbe          (s2_sbe_nxt),
    .dbe          (s2_dbe_nxt),
    .addr         (s1_addr),
    .syn          (s2_syn_nxt),
    .sbe_cnt      (sbe_cnt),
    .dbe_cnt      (dbe_cnt),
    .log_valid    (log_valid),
    .log_is_dbe   (log_is_dbe),
    .log_addr     (log_addr),
    .log_lane     (log_lane),
    .log_syndrome (log_syndrome),
    .irq_dbe      (irq_dbe)
  );

endmodule

// File: tb/tb_ecc_pipe_engine.sv
// Scoreboard bench for ecc_pipe_engine: directed error cases, backpressure, saturation, bypass, reset.
module tb_ecc_pipe_engine;

  localparam int L  = 2;
  localparam int AW = 32;
  localparam int CW = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ecc_en = 1'b1;
  logic wr_in_valid = 1'b0, wr_out_ready = 1'b1;
  logic rd_in_valid = 1'b0, rd_out_ready = 1'b1;
  logic err_clr = 1'b0;
  logic [127:0] wr_in_data = '0, rd_in_data = '0;
  logic [15:0]  rd_in_ecc = '0;
  logic [AW-1:0] rd_in_addr = '0;
  logic wr_in_ready, wr_out_valid, rd_in_ready, rd_out_valid;
  logic [127:0] wr_out_data, rd_out_data;
  logic [15:0]  wr_out_ecc;
  logic [AW-1:0] rd_out_addr, log_addr;
  logic [1:0] rd_out_sbe, rd_out_dbe;
  logic [CW-1:0] sbe_cnt, dbe_cnt;
  logic log_valid, log_is_dbe, irq_dbe;
  logic [0:0] log_lane;
  logic [7:0] log_syndrome;

  always #5 clk = ~clk;

  ecc_pipe_engine #(.LANES(L), .ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n), .ecc_en(ecc_en),
    .wr_in_valid(wr_in_valid), .wr_in_ready(wr_in_ready), .wr_in_data(wr_in_data),
    .wr_out_valid(wr_out_valid), .wr_out_ready(wr_out_ready),
    .wr_out_data(wr_out_data), .wr_out_ecc(wr_out_ecc),
    .rd_in_valid(rd_in_valid), .rd_in_ready(rd_in_ready), .rd_in_data(rd_in_data),
    .rd_in_ecc(rd_in_ecc), .rd_in_addr(rd_in_addr),
    .rd_out_valid(rd_out_valid), .rd_out_ready(rd_out_ready), .rd_out_data(rd_out_data),
    .rd_out_addr(rd_out_addr), .rd_out_sbe(rd_out_sbe), .rd_out_dbe(rd_out_dbe),
    .err_clr(err_clr), .sbe_cnt(sbe_cnt), .dbe_cnt(dbe_cnt),
    .log_valid(log_valid), .log_is_dbe(log_is_dbe), .log_addr(log_addr),
    .log_lane(log_lane), .log_syndrome(log_syndrome), .irq_dbe(irq_dbe)
  );

  typedef struct {
    logic [127:0] d;
    logic [AW-1:0] a;
    logic [1:0] s;
    logic [1:0] b;
    bit dchk;
    bit lat;
    int c;
  } rexp_t;

  typedef struct {
    logic [127:0] d;
    logic [15:0] e;
    bit lat;
    int c;
  } wexp_t;

  rexp_t rq[$];
  wexp_t wq[$];
  int cyc = 0;
  int n_cmp = 0, n_err = 0;
  bit mon_en = 1'b1;
  bit bp_stop = 1'b0;
  bit r_held = 1'b0, w_held = 1'b0;
  logic [127:0] r_hd, w_hd;
  logic [AW-1:0] r_ha;
  logic [15:0] w_he;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h exp %0h", tag, got, exp);
    end
  endtask

  // Reference code: check bits make the XOR of the positions of all set codeword bits zero
  function automatic logic [7:0] enc(input logic [63:0] d);
    logic [6:0] x;
    int j;
    x = '0;
    j = 0;
    for (int p = 1; p < 72; p++) begin
      if ((p & (p - 1)) != 0) begin
        if (d[j]) x = x ^ 7'(p);
        j++;
      end
    end
    return {(^d) ^ (^x), x};
  endfunction

  function automatic logic [15:0] mk_ecc(input logic [127:0] d);
    return {enc(d[127:64]), enc(d[63:0])};
  endfunction

  task automatic rd_mon();
    rexp_t e;
    if (!rst_n || !mon_en) begin
      r_held = 1'b0;
      return;
    end
    if (r_held && !rd_out_valid) chk("rd_valid_drop", 0, 1);
    if (rd_out_valid) begin
      if (r_held) begin
        chk("rd_hold_data", rd_out_data, r_hd);
        chk("rd_hold_addr", rd_out_addr, r_ha);
      end
      if (rd_out_ready) begin
        r_held = 1'b0;
        if (rq.size() == 0) chk("rd_extra_beat", 1, 0);
        else begin
          e = rq.pop_front();
          if (e.dchk) chk("rd_data", rd_out_data, e.d);
          chk("rd_addr", rd_out_addr, e.a);
          chk("rd_sbe", rd_out_sbe, e.s);
          chk("rd_dbe", rd_out_dbe, e.b);
          if (e.lat) chk("rd_latency", cyc - e.c, 2);
        end
      end else begin
        r_held = 1'b1;
        r_hd = rd_out_data;
        r_ha = rd_out_addr;
      end
    end
  endtask

  task automatic wr_mon();
    wexp_t e;
    if (!rst_n || !mon_en) begin
      w_held = 1'b0;
      return;
    end
    if (w_held && !wr_out_valid) chk("wr_valid_drop", 0, 1);
    if (wr_out_valid) begin
      if (w_held) begin
        chk("wr_hold_data", wr_out_data, w_hd);
        chk("wr_hold_ecc", wr_out_ecc, w_he);
      end
      if (wr_out_ready) begin
        w_held = 1'b0;
        if (wq.size() == 0) chk("wr_extra_beat", 1, 0);
        else begin
          e = wq.pop_front();
          chk("wr_data", wr_out_data, e.d);
          chk("wr_ecc", wr_out_ecc, e.e);
          if (e.lat) chk("wr_latency", cyc - e.c, 1);
        end
      end else begin
        w_held = 1'b1;
        w_hd = wr_out_data;
        w_he = wr_out_ecc;
      end
    end
  endtask

  always @(negedge clk) begin
    rd_mon();
    wr_mon();
  end

  // Callers enter just after a rising edge; returns just after the accepting edge
  task automatic send_rd(input logic [127:0] rd, input logic [15:0] re, input logic [AW-1:0] a,
                         input logic en, input logic [127:0] xd, input logic [1:0] xs,
                         input logic [1:0] xb, input bit dchk, input bit lat);
    rexp_t e;
    bit got;
    rd_in_valid = 1'b1; rd_in_data = rd; rd_in_ecc = re; rd_in_addr = a; ecc_en = en;
    got = 1'b0;
    for (int t = 0; t < 300 && !got; t++) begin
      @(negedge clk);
      if (rd_in_ready) got = 1'b1;
    end
    if (!got) chk("rd_in_timeout", 0, 1);
    else begin
      e.d = xd; e.a = a; e.s = xs; e.b = xb; e.dchk = dchk; e.lat = lat; e.c = cyc;
      rq.push_back(e);
    end
    @(posedge clk); #1;
    rd_in_valid = 1'b0;
  endtask

  task automatic send_wr(input logic [127:0] d, input logic en, input bit lat);
    wexp_t e;
    bit got;
    wr_in_valid = 1'b1; wr_in_data = d; ecc_en = en;
    got = 1'b0;
    for (int t = 0; t < 300 && !got; t++) begin
      @(negedge clk);
      if (wr_in_ready) got = 1'b1;
    end
    if (!got) chk("wr_in_timeout", 0, 1);
    else begin
      e.d = d; e.e = en ? mk_ecc(d) : 16'h0; e.lat = lat; e.c = cyc;
      wq.push_back(e);
    end
    @(posedge clk); #1;
    wr_in_valid = 1'b0;
  endtask

  // Clean or single-bit-corrupted beat (data or check bit) per lane
  task automatic rnd_rd(input logic [AW-1:0] a, input bit lat, input bit allow_err);
    logic [127:0] d, rd;
    logic [15:0] e, re;
    logic [1:0] xs;
    int k;
    d = {$urandom, $urandom, $urandom, $urandom};
    e = mk_ecc(d); rd = d; re = e; xs = '0;
    for (int l = 0; l < 2; l++) begin
      k = allow_err ? $urandom_range(0, 2) : 0;
      if (k == 1) begin rd[l*64 + $urandom_range(0, 63)] ^= 1'b1; xs[l] = 1'b1; end
      if (k == 2) begin re[l*8 + $urandom_range(0, 7)] ^= 1'b1; xs[l] = 1'b1; end
    end
    send_rd(rd, re, a, 1'b1, d, xs, 2'b00, 1'b1, lat);
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    for (int t = 0; t < 300 && !done; t++) begin
      @(negedge clk);
      if (rq.size() == 0 && wq.size() == 0) done = 1'b1;
    end
    if (!done) chk("drain_timeout", rq.size() + wq.size(), 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
  endtask

  task automatic clear_pulse();
    @(posedge clk); #1;
    err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
  endtask

  logic [127:0] d0;
  logic [15:0] e0;

  initial begin
    #12;
    chk("rst_rd_valid", rd_out_valid, 0);
    chk("rst_wr_valid", wr_out_valid, 0);
    chk("rst_cnts", {sbe_cnt, dbe_cnt}, 0);
    chk("rst_log", {log_valid, log_is_dbe, irq_dbe}, 0);
    chk("rst_rd_data", rd_out_data, 0);
    chk("rst_wr_ecc", wr_out_ecc, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_ready", {wr_in_ready, rd_in_ready}, 2'b11);

    // clean back-to-back traffic
    for (int i = 0; i < 100; i++) send_wr({$urandom, $urandom, $urandom, $urandom}, 1'b1, 1'b1);
    for (int i = 0; i < 100; i++) rnd_rd(32'h100 + 32'(i), 1'b1, 1'b0);
    drain();
    chk("clean_cnts", {sbe_cnt, dbe_cnt}, 0);
    chk("clean_log", log_valid, 0);

    // SBE lane 1 bit 5 at 0x1000
    d0 = {$urandom, $urandom, $urandom, $urandom};
    e0 = mk_ecc(d0);
    send_rd(d0 ^ (128'h1 << 69), e0, 32'h1000, 1'b1, d0, 2'b10, 2'b00, 1'b1, 1'b1);
    drain();
    chk("sbe_cnt1", sbe_cnt, 1);
    chk("sbe_log_valid", {log_valid, log_is_dbe}, 2'b10);
    chk("sbe_log_addr", log_addr, 32'h1000);
    chk("sbe_log_lane", log_lane, 1);
    chk("sbe_log_syn", log_syndrome, 8'h8A);

    // SBE then DBE upgrade, then a second DBE must not move the log
    clear_pulse();
    d0 = {$urandom, $urandom, $urandom, $urandom};
    send_rd(d0 ^ (128'h1 << 5), mk_ecc(d0), 32'h2000, 1'b1, d0, 2'b01, 2'b00, 1'b1, 1'b0);
    drain();
    chk("log2_addr", log_addr, 32'h2000);
    chk("log2_irq", irq_dbe, 0);
    d0 = {$urandom, $urandom, $urandom, $urandom};
    send_rd(d0 ^ 128'h3, mk_ecc(d0), 32'h3000, 1'b1, d0, 2'b00, 2'b01, 1'b0, 1'b0);
    drain();
    chk("log3_addr", log_addr, 32'h3000);
    chk("log3_lane", log_lane, 0);
    chk("log3_dbe_irq", {log_is_dbe, irq_dbe}, 2'b11);
    chk("log3_syn", log_syndrome, 8'h06);
    d0 = {$urandom, $urandom, $urandom, $urandom};
    send_rd(d0 ^ (128'h3 << 70), mk_ecc(d0), 32'h4000, 1'b1, d0, 2'b00, 2'b10, 1'b0, 1'b0);
    drain();
    chk("log4_addr", log_addr, 32'h3000);
    chk("log4_lane", log_lane, 0);
    chk("dbe_cnt2", dbe_cnt, 2);
    chk("sbe_cnt_after_dbe", sbe_cnt, 1);

    // saturation of the 4-bit counter
    clear_pulse();
    chk("clr_cnts", {sbe_cnt, dbe_cnt}, 0);
    chk("clr_log", {log_valid, irq_dbe}, 0);
    for (int i = 0; i < 20; i++) begin
      d0 = {$urandom, $urandom, $urandom, $urandom};
      send_rd(d0 ^ (128'h1 << $urandom_range(0, 63)), mk_ecc(d0), 32'h5000 + 32'(i), 1'b1,
              d0, 2'b01, 2'b00, 1'b1, 1'b1);
    end
    drain();
    chk("sbe_sat", sbe_cnt, 15);

    // clear coincident with an SBE beat entering S2
    clear_pulse();
    d0 = {$urandom, $urandom, $urandom, $urandom};
    send_rd(d0 ^ (128'h1 << 100), mk_ecc(d0), 32'h6000, 1'b1, d0, 2'b10, 2'b00, 1'b1, 1'b1);
    err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
    drain();
    chk("clr_race_cnt", sbe_cnt, 0);
    chk("clr_race_log", log_valid, 0);

    // bypass: corrupted data passes raw, no flags, zero check bits
    d0 = {$urandom, $urandom, $urandom, $urandom};
    send_rd(d0 ^ 128'h3 ^ (128'h1 << 71), mk_ecc(d0), 32'h7000, 1'b0,
            d0 ^ 128'h3 ^ (128'h1 << 71), 2'b00, 2'b00, 1'b1, 1'b1);
    send_wr(d0, 1'b0, 1'b1);
    drain();
    chk("bypass_cnts", {sbe_cnt, dbe_cnt}, 0);

    // random backpressure on both outputs
    fork
      begin
        while (!bp_stop) begin
          @(posedge clk); #1;
          rd_out_ready = 1'($urandom_range(0, 1));
          wr_out_ready = 1'($urandom_range(0, 1));
        end
      end
      begin
        for (int i = 0; i < 60; i++) rnd_rd(32'h8000 + 32'(i), 1'b0, 1'b1);
      end
      begin
        for (int i = 0; i < 40; i++) send_wr({$urandom, $urandom, $urandom, $urandom}, 1'b1, 1'b0);
        bp_stop = 1'b1;
      end
    join
    rd_out_ready = 1'b1;
    wr_out_ready = 1'b1;
    drain();

    // asynchronous reset in the middle of a burst
    mon_en = 1'b0;
    rd_in_valid = 1'b1;
    wr_in_valid = 1'b1;
    rd_in_data = 128'h1;
    rd_in_ecc = '0;
    repeat (4) @(posedge clk);
    #2;
    chk("pre_rst_valids", {rd_out_valid, wr_out_valid}, 2'b11);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valids", {rd_out_valid, wr_out_valid}, 2'b00);
    chk("mid_rst_cnts", {sbe_cnt, dbe_cnt}, 0);
    chk("mid_rst_log", {log_valid, irq_dbe}, 0);
    chk("mid_rst_data", rd_out_data, 0);
    rd_in_valid = 1'b0;
    wr_in_valid = 1'b0;
    rq.delete();
    wq.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_valids", {rd_out_valid, wr_out_valid}, 2'b00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ecc_pipe_engine.md
# ecc_pipe_engine

Pipelined, multi-lane SECDED engine between the DDR2 server controller's data path and the PHY. It replaces the purely combinational ECC wrapper with registered encode and decode paths under valid/ready flow control. It instantiates `ecc_secded` once per lane per path, and adds saturating error counters and a first-error log for RAS software.

## Interface
- `LANES`, 2: 64-bit data lanes per beat.
- `DATA_WIDTH`, 64: data bits per lane.
- `PARITY_BITS`, 7: SECDED parity bits; ECC width per lane is `PARITY_BITS+1`, written `EW` below.
- `ADDR_WIDTH`, 32: width of the beat address tag.
- `CNT_WIDTH`, 16: error counter width.

Ports (name, direction, width, meaning):
- `clk`  in  1  sole clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `ecc_en`  in  1  ECC enable; sampled per beat at acceptance.
- `wr_in_valid`  in  1  write beat valid.
- `wr_in_ready`  out  1  write beat accepted.
- `wr_in_data`  in  LANES*DATA_WIDTH  write data.
- `wr_out_valid`  out  1  encoded beat valid.
- `wr_out_ready`  in  1  PHY accepts encoded beat.
- `wr_out_data`  out  LANES*DATA_WIDTH  write data, delayed.
- `wr_out_ecc`  out  LANES*EW  check bits.
- `rd_in_valid`  in  1  read beat valid.
- `rd_in_ready`  out  1  read beat accepted.
- `rd_in_data`  in  LANES*DATA_WIDTH  raw read data.
- `rd_in_ecc`  in  LANES*EW  raw check bits.
- `rd_in_addr`  in  ADDR_WIDTH  beat address tag.
- `rd_out_valid`  out  1  corrected beat valid.
- `rd_out_ready`  in  1  consumer accepts beat.
- `rd_out_data`  out  LANES*DATA_WIDTH  corrected data.
- `rd_out_addr`  out  ADDR_WIDTH  address tag.
- `rd_out_sbe`  out  LANES  per-lane corrected single-bit error.
- `rd_out_dbe`  out  LANES  per-lane uncorrectable error.
- `err_clr`  in  1  one-cycle pulse; clears counters and log.
- `sbe_cnt`  out  CNT_WIDTH  saturating count of SBE lanes.
- `dbe_cnt`  out  CNT_WIDTH  saturating count of DBE lanes.
- `log_valid`  out  1  error log holds an entry.
- `log_is_dbe`  out  1  logged error was uncorrectable.
- `log_addr`  out  ADDR_WIDTH  address of the logged beat.
- `log_lane`  out  $clog2(LANES) (minimum 1)  lane index of the logged error.
- `log_syndrome`  out  EW  syndrome of the logged error.
- `irq_dbe`  out  1  level interrupt; equals `log_valid & log_is_dbe`.

## Operation
- Write path: one register stage. `ecc_out` is computed from `wr_in_data` on acceptance; when `ecc_en=0` the captured check bits are 0.
- Read path: two register stages.
  - S1 captures data, ecc, addr and `ecc_en`.
  - The `ecc_secded` decode is computed from S1.
  - S2 captures corrected data, per-lane flags and syndromes.
- Bypass: with S1 `ecc_en=0`, S2 takes raw data and all flags are 0. Latency is unchanged.
- Counters update when a beat enters S2: `sbe_cnt += popcount(sbe)` and `dbe_cnt += popcount(dbe)`, saturating at all-ones with no wrap.
- Error log update, on a beat entering S2 that carries any error:
  - If `!log_valid`, capture the lowest-index erroring lane, preferring a DBE lane over an SBE lane within the beat.
  - If `log_valid & !log_is_dbe` and the beat has a DBE, overwrite once with the DBE lane.
  - Otherwise hold.
- `err_clr` zeroes counters and the log. If `err_clr` coincides with an update in the same cycle, the clear wins and that beat's errors are dropped.

## Timing
- Reset: every valid output, counter, log field and `irq_dbe` is 0; data registers are 0. `wr_in_ready` and `rd_in_ready` are 1 after reset (pipelines empty).
- Read pipeline enables:
  - `s2_en = !s2_valid | rd_out_ready`
  - `s1_en = !s1_valid | s2_en`
  - `rd_in_ready = s1_en`
  - The ready path is combinational and there are no bubbles.
- Write path: `wr_in_ready = !wr_out_valid | wr_out_ready`.
- Latency with the consumer always ready: write 1 cycle, read 2 cycles. Sustained throughput is 1 beat per clock.
- Handshake: a transfer occurs when valid and ready are both high on a rising edge. An output held under backpressure keeps its data and flags stable. Valid never drops without a transfer.
- Asynchronous reset mid-stream discards in-flight beats; outputs are zero immediately.
- `irq_dbe` rises the cycle after the first DBE beat enters S2.

## Structure
- Package `ecc_pipe_pkg`:
  - `EW` (derived ECC width).
  - Lane-index width function.
  - Per-lane decode result struct (data, sbe, dbe, syndrome).
  - Saturating-add helper.
- Sub-module `ecc_err_log`: counters, log and the clear arbitration.
- Per-lane `ecc_secded` instances sit in generate loops for the encode and decode paths.

## Test plan
- Clean traffic, LANES=2, 100 beats back to back, always ready -> data matches, latency 2 (read) / 1 (write), flags 0, counters 0.
- Flip bit 5 of lane 1 at addr `0x1000` -> data corrected, `rd_out_sbe=2'b10`, `sbe_cnt=1`, log shows addr `0x1000`, lane 1, `log_is_dbe=0`.
- SBE at `0x2000` then DBE in lane 0 at `0x3000` -> log overwritten to `0x3000`, lane 0, `irq_dbe=1`; a second DBE leaves the log unchanged while `dbe_cnt=2`.
- Random `rd_out_ready` toggling -> no drops or duplicates, held outputs stable, order preserved.
- `sbe_cnt` preloaded near max with CNT_WIDTH=4 and 20 SBE beats -> `sbe_cnt` stays at 15; `err_clr` in the same cycle as an SBE -> counts 0, log invalid.
- `ecc_en=0` with corrupted data -> raw data out, no flags, `wr_out_ecc=0`; reset asserted mid-burst -> all valids 0 at once.
